spi_master: RTL and testbench

//  Fabric-side SPI master. It is the initiating end of the link that our SPI slave answers.
//  - Serialises bytes MSb-first on o_SPI_MOSI and captures i_SPI_MISO into received bytes.
//  - Generates o_SPI_Clk and o_SPI_CS_n, and keeps CS low for a multi-byte transaction.
//  - Uses the same four SPI modes as the slave, so a master/slave pair can be looped back in the core.

---
 rtl/spi_master.sv | 181 ++++++++++++++++++
 tb/tb_spi_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: fabric-side SPI master, the initiating end of the link that the
// SPI slave answers. Bytes go out MSb-first on o_SPI_MOSI while i_SPI_MISO is
// shifted into the received byte. Chip select stays low across a multi-byte
// transaction. The four standard SPI modes are supported.
//
// Ports:
//   w_SPI_Clk   in   fabric clock, rising-edge logic
//   i_Rst_L     in   asynchronous reset, active low
//   i_TX_Count  in   bytes in the transaction, sampled on the first byte only
//   i_TX_Byte   in   byte to send, sampled with i_TX_DV
//   i_TX_DV     in   one-cycle strobe, accepted only while o_TX_Ready=1
//   o_TX_Ready  out  master can accept the next byte
//   o_RX_Count  out  0-based index of the byte just received within this CS
//   o_RX_DV     out  one-cycle pulse, o_RX_Byte valid
//   o_RX_Byte   out  byte captured from MISO
//   o_SPI_Clk   out  SCLK, idles at CPOL
//   i_SPI_MISO  in   serial data in
//   o_SPI_MOSI  out  serial data out
//   o_SPI_CS_n  out  chip select, active low
module spi_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 4,
  parameter int CS_INACTIVE_CLKS  = 4
) (
  input  logic                                    w_SPI_Clk,
  input  logic                                    i_Rst_L,
  input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0]   i_TX_Count,
  input  logic [7:0]                              i_TX_Byte,
  input  logic                                    i_TX_DV,
  output logic                                    o_TX_Ready,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0]   o_RX_Count,
  output logic                                    o_RX_DV,
  output logic [7:0]                              o_RX_Byte,
  output logic                                    o_SPI_Clk,
  input  logic                                    i_SPI_MISO,
  output logic                                    o_SPI_MOSI,
  output logic                                    o_SPI_CS_n
);

  localparam int   CW   = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   TMAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ? CLKS_PER_HALF_BIT
                                                                 : CS_INACTIVE_CLKS;
  localparam int   TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, XFER, WAIT_NEXT, CS_HOLD, CS_GAP} state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [3:0]      edge_cnt;
  logic [7:0]      tx_shift;
  logic [7:0]      rx_shift;
  logic [CW-1:0]   tx_count;
  logic [CW-1:0]   byte_idx;
  logic            rx_pend;
  logic [CW-1:0]   cnt_clamped;

  // A count of zero still moves one byte; anything above the limit is clamped.
  always_comb begin
    cnt_clamped = i_TX_Count;
    if (i_TX_Count == '0)
      cnt_clamped = CW'(1);
    else if (i_TX_Count > CW'(MAX_BYTES_PER_CS))
      cnt_clamped = CW'(MAX_BYTES_PER_CS);
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= IDLE;
      tmr        <= '0;
      edge_cnt   <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      tx_count   <= '0;
      byte_idx   <= '0;
      rx_pend    <= 1'b0;
      o_TX_Ready <= 1'b1;
      o_RX_Count <= '0;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= '0;
      o_SPI_Clk  <= CPOL;
      o_SPI_MOSI <= 1'b0;
      o_SPI_CS_n <= 1'b1;
    end else begin
      o_RX_DV <= 1'b0;
      rx_pend <= 1'b0;

      // Delivery lags the 16th edge by one cycle so the final trailing-edge
      // sample (CPHA=1) is already in rx_shift.
      if (rx_pend) begin
        o_RX_DV    <= 1'b1;
        o_RX_Byte  <= rx_shift;
        o_RX_Count <= byte_idx;
        byte_idx   <= byte_idx + CW'(1);
      end

      case (state)
        IDLE: begin
          if (i_TX_DV && o_TX_Ready) begin
            tx_shift   <= i_TX_Byte;
            tx_count   <= cnt_clamped;
            byte_idx   <= '0;
            o_RX_Count <= '0;
            o_TX_Ready <= 1'b0;
            o_SPI_CS_n <= 1'b0;
            state      <= LOAD;
          end
        end

        LOAD: begin
          tmr      <= '0;
          edge_cnt <= '0;
          if (!CPHA) begin
            o_SPI_MOSI <= tx_shift[7];
            tx_shift   <= {tx_shift[6:0], 1'b0};
          end
          state <= XFER;
        end

        XFER: begin
          if (tmr == TW'(CLKS_PER_HALF_BIT - 1)) begin
            tmr       <= '0;
            o_SPI_Clk <= ~o_SPI_Clk;
            edge_cnt  <= edge_cnt + 4'd1;
            // Even edge index = leading edge, odd = trailing edge.
            if (edge_cnt[0] == CPHA) begin
              rx_shift <= {rx_shift[6:0], i_SPI_MISO};
            end else if (edge_cnt != 4'd15) begin
              o_SPI_MOSI <= tx_shift[7];
              tx_shift   <= {tx_shift[6:0], 1'b0};
            end
            if (edge_cnt == 4'd15) begin
              rx_pend <= 1'b1;
              if (byte_idx == tx_count - CW'(1)) begin
                state <= CS_HOLD;
              end else begin
                o_TX_Ready <= 1'b1;
                state      <= WAIT_NEXT;
              end
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        WAIT_NEXT: begin
          if (i_TX_DV) begin
            tx_shift   <= i_TX_Byte;
            o_TX_Ready <= 1'b0;
            state      <= LOAD;
          end
        end

        CS_HOLD: begin
          if (tmr == TW'(CLKS_PER_HALF_BIT - 1)) begin
            tmr        <= '0;
            o_SPI_CS_n <= 1'b1;
            state      <= CS_GAP;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        CS_GAP: begin
          if (tmr == TW'(CS_INACTIVE_CLKS - 1)) begin
            tmr        <= '0;
            o_TX_Ready <= 1'b1;
            state      <= IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: four instances (modes 0..3) share the same byte
// stream. A behavioural slave per instance either loops MOSI back or returns
// a fixed byte, and captures MOSI on its sampling edges.
module tb_spi_master;

  localparam int NM   = 4;
  localparam int MAXB = 4;
  localparam int CHB  = 2;
  localparam int CSI  = 4;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [2:0] tb_count;
  logic [7:0] tb_byte;
  logic       tb_dv;

  logic [NM-1:0] rdy_w, rxdv_w, sclk_w, mosi_w, cs_w, miso_w;
  logic [NM-1:0] s_miso;
  logic [7:0]    rxbyte_w [NM];
  logic [2:0]    rxcnt_w  [NM];

  logic       loopback;
  logic [7:0] slave_tx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NM; g++) begin : g_dut
    spi_master #(
      .SPI_MODE(g),
      .CLKS_PER_HALF_BIT(CHB),
      .MAX_BYTES_PER_CS(MAXB),
      .CS_INACTIVE_CLKS(CSI)
    ) u_dut (
      .w_SPI_Clk (clk),
      .i_Rst_L   (rst_l),
      .i_TX_Count(tb_count),
      .i_TX_Byte (tb_byte),
      .i_TX_DV   (tb_dv),
      .o_TX_Ready(rdy_w[g]),
      .o_RX_Count(rxcnt_w[g]),
      .o_RX_DV   (rxdv_w[g]),
      .o_RX_Byte (rxbyte_w[g]),
      .o_SPI_Clk (sclk_w[g]),
      .i_SPI_MISO(miso_w[g]),
      .o_SPI_MOSI(mosi_w[g]),
      .o_SPI_CS_n(cs_w[g])
    );
    assign miso_w[g] = loopback ? mosi_w[g] : s_miso[g];
  end

  function automatic logic cpol_of(input int m);
    return (m >= 2);
  endfunction

  function automatic logic cpha_of(input int m);
    return (m % 2 == 1);
  endfunction

  // ---------------- monitor + slave model ----------------
  logic [NM-1:0] sclk_prev, mosi_prev, cs_prev, rdy_prev;
  int edges[NM], total_edges[NM], hi_edges[NM], ready_edges[NM];
  int unstable[NM], idle_bad[NM], low_cnt[NM], last_low[NM];
  int gap_cnt[NM], last_gap[NM], sbit[NM], scnt[NM];
  logic [7:0] s_in[NM];
  logic [7:0] rxb[NM][$];
  logic [2:0] rxc[NM][$];
  logic [7:0] slave_rx[NM][$];

  initial begin
    s_miso = '0;
    for (int m = 0; m < NM; m++) begin
      edges[m] = 0; total_edges[m] = 0; hi_edges[m] = 0; ready_edges[m] = 0;
      unstable[m] = 0; idle_bad[m] = 0; low_cnt[m] = 0; last_low[m] = 0;
      gap_cnt[m] = 0; last_gap[m] = 0; sbit[m] = 0; scnt[m] = 0; s_in[m] = '0;
    end
    @(negedge clk);
    sclk_prev = sclk_w; mosi_prev = mosi_w; cs_prev = cs_w; rdy_prev = rdy_w;
    forever begin
      @(negedge clk);
      for (int m = 0; m < NM; m++) begin
        if (cs_w[m] != cs_prev[m]) begin
          if (sclk_w[m] != cpol_of(m)) idle_bad[m]++;
          if (!cs_w[m]) begin
            edges[m] = 0; sbit[m] = 0; scnt[m] = 0; low_cnt[m] = 0;
            if (!cpha_of(m)) s_miso[m] = slave_tx[7];
          end else begin
            last_low[m] = low_cnt[m];
            gap_cnt[m]  = 0;
          end
        end
        if (sclk_w[m] != sclk_prev[m]) begin
          if (cs_w[m]) begin
            hi_edges[m]++;
          end else begin
            edges[m]++;
            total_edges[m]++;
            if (rdy_w[m] && rdy_prev[m]) ready_edges[m]++;
            if ((sclk_w[m] != cpol_of(m)) != cpha_of(m)) begin
              // sampling edge
              if (mosi_w[m] != mosi_prev[m]) unstable[m]++;
              s_in[m] = {s_in[m][6:0], mosi_w[m]};
              scnt[m]++;
              if (scnt[m] == 8) begin
                slave_rx[m].push_back(s_in[m]);
                scnt[m] = 0;
              end
            end else if (cpha_of(m)) begin
              s_miso[m] = slave_tx[7 - sbit[m]];
              sbit[m]   = (sbit[m] + 1) % 8;
            end else begin
              sbit[m]   = (sbit[m] + 1) % 8;
              s_miso[m] = slave_tx[7 - sbit[m]];
            end
          end
        end
        if (!cs_w[m]) low_cnt[m]++;
        else if (!rdy_w[m]) gap_cnt[m]++;
        if (rdy_w[m] && !rdy_prev[m] && cs_w[m]) last_gap[m] = gap_cnt[m];
        if (rxdv_w[m]) begin
          rxb[m].push_back(rxbyte_w[m]);
          rxc[m].push_back(rxcnt_w[m]);
        end
      end
      sclk_prev = sclk_w; mosi_prev = mosi_w; cs_prev = cs_w; rdy_prev = rdy_w;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    tb_byte = b;
    tb_dv   = 1'b1;
    @(posedge clk);
    #1;
    tb_dv   = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!rdy_w[0] && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("tx_ready_wait", 32'(rdy_w[0]), 32'd1);
  endtask

  task automatic run_vec(input logic [2:0] cnt, input int n, input logic [3:0][7:0] b,
                         input int gap, input logic lb, input logic [7:0] sl);
    int rb[NM], sb[NM], e0[NM], u0[NM], h0[NM], r0[NM], i0[NM];
    logic [7:0] expb;
    loopback = lb;
    slave_tx = sl;
    for (int m = 0; m < NM; m++) begin
      rb[m] = rxb[m].size(); sb[m] = slave_rx[m].size();
      e0[m] = total_edges[m]; u0[m] = unstable[m]; h0[m] = hi_edges[m];
      r0[m] = ready_edges[m]; i0[m] = idle_bad[m];
    end
    wait_ready();
    tb_count = cnt;
    pulse(b[0]);
    for (int i = 1; i < n; i++) begin
      wait_ready();
      repeat (gap) @(negedge clk);
      pulse(b[i]);
    end
    wait_ready();
    @(negedge clk);
    #1;
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("m%0d rx_n", m), 32'(rxb[m].size() - rb[m]), 32'(n));
      chk($sformatf("m%0d slave_n", m), 32'(slave_rx[m].size() - sb[m]), 32'(n));
      for (int i = 0; i < n; i++) begin
        expb = lb ? b[i] : sl;
        if (rb[m] + i < rxb[m].size()) begin
          chk($sformatf("m%0d rx_byte[%0d]", m, i), 32'(rxb[m][rb[m] + i]), 32'(expb));
          chk($sformatf("m%0d rx_count[%0d]", m, i), 32'(rxc[m][rb[m] + i]), 32'(i));
        end
        if (sb[m] + i < slave_rx[m].size())
          chk($sformatf("m%0d mosi_byte[%0d]", m, i), 32'(slave_rx[m][sb[m] + i]), 32'(b[i]));
      end
      chk($sformatf("m%0d sclk_edges", m), 32'(total_edges[m] - e0[m]), 32'(16 * n));
      chk($sformatf("m%0d mosi_unstable", m), 32'(unstable[m] - u0[m]), 32'd0);
      chk($sformatf("m%0d sclk_at_cs_change", m), 32'(idle_bad[m] - i0[m]), 32'd0);
      chk($sformatf("m%0d edges_while_waiting", m), 32'(ready_edges[m] - r0[m]), 32'd0);
      chk($sformatf("m%0d edges_cs_high", m), 32'(hi_edges[m] - h0[m]), 32'd0);
      chk($sformatf("m%0d cs_n_end", m), 32'(cs_w[m]), 32'd1);
      chk($sformatf("m%0d sclk_idle", m), 32'(sclk_w[m]), 32'(cpol_of(m)));
      if (n == 1)
        chk($sformatf("m%0d cs_low_len", m), 32'(last_low[m]), 32'(1 + 16 * CHB + CHB));
      chk($sformatf("m%0d cs_gap_min", m), 32'(last_gap[m] >= CSI), 32'd1);
    end
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic [2:0]      cnt;
    int              n;
    logic [3:0][7:0] b;
    int              gap;
    logic            lb;
    logic [7:0]      sl;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb0[NM];
    int k;
    logic [3:0][7:0] rb;
    logic [2:0] rc;
    int rn;

    tbl[0] = '{3'd1, 1, 32'h0000_00A5, 0,  1'b1, 8'h00};
    tbl[1] = '{3'd1, 1, 32'h0000_00C3, 0,  1'b0, 8'h3C};
    tbl[2] = '{3'd3, 3, 32'h0003_0201, 50, 1'b1, 8'h00};
    tbl[3] = '{3'd0, 1, 32'h0000_005E, 0,  1'b1, 8'h00};
    tbl[4] = '{3'd5, 4, 32'h4433_2211, 0,  1'b1, 8'h00};
    tbl[5] = '{3'd2, 2, 32'h0000_C3C3, 3,  1'b0, 8'h3C};
    tbl[6] = '{3'd4, 4, 32'hDEAD_BEEF, 1,  1'b0, 8'h81};

    rst_l = 1'b0; tb_count = '0; tb_byte = '0; tb_dv = 1'b0;
    loopback = 1'b1; slave_tx = '0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("m%0d rst cs_n", m), 32'(cs_w[m]), 32'd1);
      chk($sformatf("m%0d rst sclk", m), 32'(sclk_w[m]), 32'(cpol_of(m)));
      chk($sformatf("m%0d rst mosi", m), 32'(mosi_w[m]), 32'd0);
      chk($sformatf("m%0d rst tx_ready", m), 32'(rdy_w[m]), 32'd1);
      chk($sformatf("m%0d rst rx_dv", m), 32'(rxdv_w[m]), 32'd0);
      chk($sformatf("m%0d rst rx_byte", m), 32'(rxbyte_w[m]), 32'd0);
      chk($sformatf("m%0d rst rx_count", m), 32'(rxcnt_w[m]), 32'd0);
    end
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 7; t++)
      run_vec(tbl[t].cnt, tbl[t].n, tbl[t].b, tbl[t].gap, tbl[t].lb, tbl[t].sl);

    // Strobe while busy must be ignored.
    loopback = 1'b1;
    for (int m = 0; m < NM; m++) rb0[m] = rxb[m].size();
    wait_ready();
    tb_count = 3'd1;
    pulse(8'h5A);
    repeat (10) @(negedge clk);
    pulse(8'hFF);
    wait_ready();
    @(negedge clk);
    #1;
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("m%0d busy_dv rx_n", m), 32'(rxb[m].size() - rb0[m]), 32'd1);
      if (rxb[m].size() > rb0[m])
        chk($sformatf("m%0d busy_dv rx_byte", m), 32'(rxb[m][rb0[m]]), 32'h5A);
    end
    repeat (20) @(negedge clk);
    #1;
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("m%0d busy_dv no_restart", m), 32'(cs_w[m]), 32'd1);
      chk($sformatf("m%0d busy_dv rx_n_after", m), 32'(rxb[m].size() - rb0[m]), 32'd1);
    end

    // Reset asserted in the middle of a byte.
    loopback = 1'b1;
    for (int m = 0; m < NM; m++) rb0[m] = rxb[m].size();
    wait_ready();
    tb_count = 3'd1;
    pulse(8'h96);
    @(negedge clk);
    #1;
    k = 0;
    while (edges[0] < 7 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("edge7_reached", 32'(edges[0] >= 7), 32'd1);
    #2 rst_l = 1'b0;
    #1;
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("m%0d midrst cs_n", m), 32'(cs_w[m]), 32'd1);
      chk($sformatf("m%0d midrst sclk", m), 32'(sclk_w[m]), 32'(cpol_of(m)));
      chk($sformatf("m%0d midrst tx_ready", m), 32'(rdy_w[m]), 32'd1);
      chk($sformatf("m%0d midrst rx_byte", m), 32'(rxbyte_w[m]), 32'd0);
      chk($sformatf("m%0d midrst mosi", m), 32'(mosi_w[m]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int m = 0; m < NM; m++)
      chk($sformatf("m%0d midrst no_rx_dv", m), 32'(rxb[m].size() - rb0[m]), 32'd0);
    run_vec(3'd1, 1, 32'h0000_0069, 0, 1'b1, 8'h00);

    // Randomised transactions against the reference model.
    for (int r = 0; r < 8; r++) begin
      rc = 3'($urandom_range(0, MAXB + 1));
      rn = (rc == 0) ? 1 : ((int'(rc) > MAXB) ? MAXB : int'(rc));
      rb = $urandom;
      run_vec(rc, rn, rb, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
